// File: rtl/costas_stream_sched.sv
// costas_stream_sched
//   Two-source AXI-Stream packet scheduler in front of a Costas loop.
//   Packets are granted whole (no preemption, no timeout) with round-robin
//   arbitration when both sources are waiting. Whenever the stream owner
//   changes, and on the first grant after reset, the Costas loop is cleared
//   by holding costas_rst for FLUSH_CYCLES cycles before data flows.
//
// Ports
//   s00_axis_aclk / s00_axis_areset : clock, synchronous active-high reset
//   s00_axis_* / s01_axis_*         : source 0 / source 1 slave streams
//   m00_axis_*                      : master stream into the Costas loop
//   costas_rst                      : loop clear, high only while flushing
//   owner                           : source currently or last granted
//   pkt_cnt0 / pkt_cnt1             : completed packets per source (wrap)
module costas_stream_sched #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FLUSH_CYCLES       = 4
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_areset,
  input  logic                            s00_axis_tvalid,
  input  logic                            s00_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                            s00_axis_tready,
  input  logic                            s01_axis_tvalid,
  input  logic                            s01_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  output logic                            s01_axis_tready,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tvalid,
  output logic                            m00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            costas_rst,
  output logic                            owner,
  output logic [15:0]                     pkt_cnt0,
  output logic [15:0]                     pkt_cnt1
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FLUSH, GRANT0, GRANT1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner, r_owner_valid, r_last_grant;
  logic [7:0]  r_flush_cnt;
  logic [15:0] r_pkt_cnt0, r_pkt_cnt1;

  logic w_any, w_sel, w_keep, w_flush_done, w_done0, w_done1;

  // Round robin only matters when both wait; otherwise take whoever is valid.
  assign w_any        = s00_axis_tvalid | s01_axis_tvalid;
  assign w_sel        = (s00_axis_tvalid & s01_axis_tvalid) ? ~r_last_grant : s01_axis_tvalid;
  // Same owner as before (and loop state still valid) skips the flush.
  assign w_keep       = r_owner_valid & (w_sel == r_owner);
  assign w_flush_done = (r_state == FLUSH) && (r_flush_cnt == FLUSH_LAST);
  assign w_done0      = (r_state == GRANT0) & s00_axis_tvalid & m00_axis_tready & s00_axis_tlast;
  assign w_done1      = (r_state == GRANT1) & s01_axis_tvalid & m00_axis_tready & s01_axis_tlast;

  always_comb begin
    w_state_nxt     = r_state;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    costas_rst      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_keep) w_state_nxt = w_sel ? GRANT1 : GRANT0;
          else        w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        costas_rst = 1'b1;
        if (w_flush_done) w_state_nxt = r_owner ? GRANT1 : GRANT0;
      end
      GRANT0: begin
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast  = s00_axis_tlast;
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        s00_axis_tready = m00_axis_tready;
        if (w_done0) w_state_nxt = IDLE;
      end
      GRANT1: begin
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast  = s01_axis_tlast;
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        s01_axis_tready = m00_axis_tready;
        if (w_done1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state       <= IDLE;
      r_owner       <= 1'b0;
      r_owner_valid <= 1'b0;
      r_last_grant  <= 1'b1;
      r_flush_cnt   <= '0;
      r_pkt_cnt0    <= '0;
      r_pkt_cnt1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_any && !w_keep) begin
        r_owner     <= w_sel;
        r_flush_cnt <= '0;
      end
      if (r_state == FLUSH) begin
        if (w_flush_done) r_owner_valid <= 1'b1;
        else              r_flush_cnt   <= r_flush_cnt + 8'd1;
      end
      if (w_done0) begin
        r_pkt_cnt0   <= r_pkt_cnt0 + 16'd1;
        r_last_grant <= 1'b0;
      end
      if (w_done1) begin
        r_pkt_cnt1   <= r_pkt_cnt1 + 16'd1;
        r_last_grant <= 1'b1;
      end
    end
  end

  assign owner    = r_owner;
  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;

endmodule
